// File: rtl/regfile_fwd_hilo_if.sv
// Bundle between the decode stage and the ID register file: read ports, in-flight
// forward slots, the WB commit port, HI/LO and the stall counter.
interface regfile_fwd_hilo_if #(
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned ADDR_W  = 5,
  parameter int unsigned NUM_RD  = 2,
  parameter int unsigned NUM_FWD = 3,
  parameter int unsigned CNT_W   = 16
);
  logic [NUM_RD*ADDR_W-1:0]   rd_addr;
  logic [NUM_RD*DATA_W-1:0]   rd_data;
  logic                       rd_stall;
  logic [NUM_FWD-1:0]         fwd_we;
  logic [NUM_FWD-1:0]         fwd_ready;
  logic [NUM_FWD*ADDR_W-1:0]  fwd_waddr;
  logic [NUM_FWD*DATA_W-1:0]  fwd_wdata;
  logic [NUM_FWD-1:0]         fwd_hi_we;
  logic [NUM_FWD-1:0]         fwd_lo_we;
  logic [NUM_FWD*DATA_W-1:0]  fwd_hi;
  logic [NUM_FWD*DATA_W-1:0]  fwd_lo;
  logic                       we;
  logic [ADDR_W-1:0]          waddr;
  logic [DATA_W-1:0]          wdata;
  logic                       hi_we;
  logic                       lo_we;
  logic [DATA_W-1:0]          hi_wdata;
  logic [DATA_W-1:0]          lo_wdata;
  logic [DATA_W-1:0]          hi_rdata;
  logic [DATA_W-1:0]          lo_rdata;
  logic [CNT_W-1:0]           stall_cnt;

  modport master (
    output rd_addr, fwd_we, fwd_ready, fwd_waddr, fwd_wdata, fwd_hi_we, fwd_lo_we,
           fwd_hi, fwd_lo, we, waddr, wdata, hi_we, lo_we, hi_wdata, lo_wdata,
    input  rd_data, rd_stall, hi_rdata, lo_rdata, stall_cnt
  );

  modport slave (
    input  rd_addr, fwd_we, fwd_ready, fwd_waddr, fwd_wdata, fwd_hi_we, fwd_lo_we,
           fwd_hi, fwd_lo, we, waddr, wdata, hi_we, lo_we, hi_wdata, lo_wdata,
    output rd_data, rd_stall, hi_rdata, lo_rdata, stall_cnt
  );
endinterface

// File: rtl/regfile_fwd_hilo.sv
// ID-stage GPR file with HI/LO, combinational forwarded reads from in-flight
// stages, load-use hazard detection and a saturating stall counter.
module regfile_fwd_hilo #(
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned ADDR_W  = 5,
  parameter int unsigned NUM_RD  = 2,
  parameter int unsigned NUM_FWD = 3,
  parameter int unsigned CNT_W   = 16
) (
  input logic              clk,
  input logic              resetn,
  regfile_fwd_hilo_if.slave bus
);
  localparam int unsigned DEPTH = 2**ADDR_W;

  logic [DATA_W-1:0]        gpr [DEPTH];
  logic [DATA_W-1:0]        hi_q;
  logic [DATA_W-1:0]        lo_q;
  logic [CNT_W-1:0]         cnt_q;
  logic [NUM_RD*DATA_W-1:0] rd_data_c;
  logic [NUM_RD-1:0]        hazard;
  logic [ADDR_W-1:0]        a;
  logic                     hit;
  logic [DATA_W-1:0]        val;
  logic [DATA_W-1:0]        hi_c;
  logic [DATA_W-1:0]        lo_c;
  logic                     hi_hit;
  logic                     lo_hit;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      for (int unsigned i = 0; i < DEPTH; i++) gpr[i] <= '0;
      hi_q  <= '0;
      lo_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (bus.we && bus.waddr != '0) gpr[bus.waddr] <= bus.wdata;
      if (bus.hi_we) hi_q <= bus.hi_wdata;
      if (bus.lo_we) lo_q <= bus.lo_wdata;
      if (bus.rd_stall && cnt_q != '1) cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  // The first matching slot ends the search even when not ready, so a pending
  // load never lets an older stage's stale value through.
  always_comb begin
    rd_data_c = '0;
    hazard    = '0;
    a         = '0;
    hit       = 1'b0;
    val       = '0;
    for (int unsigned k = 0; k < NUM_RD; k++) begin
      a   = bus.rd_addr[k*ADDR_W +: ADDR_W];
      hit = 1'b0;
      val = '0;
      if (a != '0) begin
        for (int unsigned j = 0; j < NUM_FWD; j++) begin
          if (!hit && bus.fwd_we[j] && bus.fwd_waddr[j*ADDR_W +: ADDR_W] == a) begin
            hit = 1'b1;
            if (bus.fwd_ready[j]) val = bus.fwd_wdata[j*DATA_W +: DATA_W];
            else                  hazard[k] = 1'b1;
          end
        end
        if (!hit) val = (bus.we && bus.waddr == a) ? bus.wdata : gpr[a];
      end
      rd_data_c[k*DATA_W +: DATA_W] = val;
    end
  end

  always_comb begin
    hi_c   = bus.hi_we ? bus.hi_wdata : hi_q;
    lo_c   = bus.lo_we ? bus.lo_wdata : lo_q;
    hi_hit = 1'b0;
    lo_hit = 1'b0;
    for (int unsigned j = 0; j < NUM_FWD; j++) begin
      if (!hi_hit && bus.fwd_hi_we[j]) begin
        hi_hit = 1'b1;
        hi_c   = bus.fwd_hi[j*DATA_W +: DATA_W];
      end
      if (!lo_hit && bus.fwd_lo_we[j]) begin
        lo_hit = 1'b1;
        lo_c   = bus.fwd_lo[j*DATA_W +: DATA_W];
      end
    end
  end

  assign bus.rd_data   = rd_data_c;
  assign bus.rd_stall  = |hazard;
  assign bus.hi_rdata  = hi_c;
  assign bus.lo_rdata  = lo_c;
  assign bus.stall_cnt = cnt_q;
endmodule
